// File: rtl/mux_rr_n.sv
// Registered N-channel multiplexer with valid/ready on every input and on the output.
// Selection is either by the SEL input (manual) or by a round-robin scan starting at a rotating pointer.
module mux_rr_n #(
  parameter  int BITS = 4,
  parameter  int N    = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N*BITS-1:0] D,
  input  logic [N-1:0]      VALID,
  output logic [N-1:0]      READY,
  input  logic              MODE,
  input  logic [SELW-1:0]   SEL,
  output logic [BITS-1:0]   OUT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [SELW-1:0]   OUT_SEL
);

  logic [BITS-1:0] out_q, out_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic [BITS-1:0] d_arr [N];
  logic            load;
  logic [SELW-1:0] gnt, rr_gnt, idx;
  logic            gnt_ok, rr_ok, man_ok;
  int              idx_i;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      d_arr[i] = D[i*BITS +: BITS];
    end
  end

  assign load = ~out_valid_q | OUT_READY;

  // Round-robin: first requester at or after ptr, wrapping modulo N.
  always_comb begin
    rr_gnt = '0;
    rr_ok  = 1'b0;
    idx    = '0;
    idx_i  = 0;
    for (int k = 0; k < N; k++) begin
      idx_i = int'(ptr_q) + k;
      if (idx_i >= N) idx_i = idx_i - N;
      idx = SELW'(idx_i);
      if (!rr_ok && VALID[idx]) begin
        rr_ok  = 1'b1;
        rr_gnt = idx;
      end
    end
  end

  always_comb begin
    man_ok = 1'b0;
    if (int'(SEL) < N) man_ok = VALID[SEL];
  end

  always_comb begin
    if (MODE) begin
      gnt    = rr_gnt;
      gnt_ok = rr_ok;
    end else begin
      gnt    = SEL;
      gnt_ok = man_ok;
    end
  end

  // reset_n gates READY so no channel sees a handshake while the block is held in reset.
  always_comb begin
    READY = '0;
    for (int i = 0; i < N; i++) begin
      READY[i] = reset_n & load & gnt_ok & (gnt == SELW'(i));
    end
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = gnt_ok;
      if (gnt_ok) begin
        out_d     = d_arr[gnt];
        out_sel_d = gnt;
        ptr_d     = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign OUT       = out_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_SEL   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n (N=4, BITS=4): reset, manual select, round-robin order,
// skip/wrap, backpressure and withdrawn requests, each scenario checking its own results.
module tb_mux_rr_n;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] D = '0;
  logic [3:0]  VALID = '0;
  logic [3:0]  READY;
  logic        MODE = 1'b0;
  logic [1:0]  SEL = '0;
  logic [3:0]  OUT;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [1:0]  OUT_SEL;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mux_rr_n #(.BITS(4), .N(4)) dut (
    .clock(clock), .reset_n(reset_n), .D(D), .VALID(VALID), .READY(READY),
    .MODE(MODE), .SEL(SEL), .OUT(OUT), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_SEL(OUT_SEL)
  );

  task automatic test_reset();
    #2 reset_n = 1'b0;
    VALID = 4'b1111;
    #2;
    n_checks++; if (OUT !== 4'h0) begin n_fail++; $display("FAIL por_out got %h exp 0", OUT); end
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL por_out_valid got %b exp 0", OUT_VALID); end
    n_checks++; if (OUT_SEL !== 2'd0) begin n_fail++; $display("FAIL por_out_sel got %0d exp 0", OUT_SEL); end
    n_checks++; if (READY !== 4'b0000) begin n_fail++; $display("FAIL por_ready got %b exp 0000", READY); end
    @(negedge clock);
    reset_n = 1'b1;
    MODE = 1'b0; SEL = 2'd1; VALID = 4'b0010; D = 16'h0050; OUT_READY = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (OUT_VALID !== 1'b1 || OUT !== 4'h5) begin
      n_fail++; $display("FAIL pre_reset_load got v=%b out=%h exp v=1 out=5", OUT_VALID, OUT);
    end
    // Assert reset mid-stream, checking before any further clock edge.
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++; if (OUT !== 4'h0) begin n_fail++; $display("FAIL async_rst_out got %h exp 0", OUT); end
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %b exp 0", OUT_VALID); end
    n_checks++; if (OUT_SEL !== 2'd0) begin n_fail++; $display("FAIL async_rst_sel got %0d exp 0", OUT_SEL); end
    n_checks++; if (READY !== 4'b0000) begin n_fail++; $display("FAIL async_rst_ready got %b exp 0000", READY); end
    @(negedge clock);
    VALID = 4'b0000;
    reset_n = 1'b1;
  endtask

  task automatic test_manual();
    @(negedge clock);
    MODE = 1'b0; SEL = 2'd2; VALID = 4'b0100; D = 16'h3A61; OUT_READY = 1'b1;
    #1;
    n_checks++; if (READY !== 4'b0100) begin n_fail++; $display("FAIL man_ready got %b exp 0100", READY); end
    @(posedge clock); #1;
    n_checks++; if (OUT !== 4'hA || OUT_SEL !== 2'd2 || OUT_VALID !== 1'b1) begin
      n_fail++; $display("FAIL man_out got out=%h sel=%0d v=%b exp out=a sel=2 v=1", OUT, OUT_SEL, OUT_VALID);
    end
    @(negedge clock);
    SEL = 2'd3;
    #1;
    n_checks++; if (READY !== 4'b0000) begin n_fail++; $display("FAIL man_noreq_ready got %b exp 0000", READY); end
    @(posedge clock); #1;
    n_checks++; if (OUT_VALID !== 1'b0 || OUT !== 4'hA || OUT_SEL !== 2'd2) begin
      n_fail++; $display("FAIL man_noreq_out got v=%b out=%h sel=%0d exp v=0 out=a sel=2", OUT_VALID, OUT, OUT_SEL);
    end
    // Granting channel 3 wraps the pointer back to 0 in manual mode too.
    @(negedge clock);
    VALID = 4'b1000;
    #1;
    n_checks++; if (READY !== 4'b1000) begin n_fail++; $display("FAIL man_ch3_ready got %b exp 1000", READY); end
    @(posedge clock); #1;
    n_checks++; if (OUT !== 4'h3 || OUT_SEL !== 2'd3 || OUT_VALID !== 1'b1) begin
      n_fail++; $display("FAIL man_ch3_out got out=%h sel=%0d v=%b exp out=3 sel=3 v=1", OUT, OUT_SEL, OUT_VALID);
    end
  endtask

  task automatic test_rr_fair();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      MODE = 1'b1; VALID = 4'b1111; D = 16'hDCBA; OUT_READY = 1'b1;
      #1;
      n_checks++; if (READY !== (4'b0001 << exp_g[i])) begin
        n_fail++; $display("FAIL rr_fair_ready[%0d] got %b exp grant %0d", i, READY, exp_g[i]);
      end
      @(posedge clock); #1;
      n_checks++; if (OUT_SEL !== 2'(exp_g[i]) || OUT !== 4'(4'hA + exp_g[i]) || OUT_VALID !== 1'b1) begin
        n_fail++; $display("FAIL rr_fair_out[%0d] got sel=%0d out=%h v=%b exp sel=%0d", i, OUT_SEL, OUT, OUT_VALID, exp_g[i]);
      end
    end
  endtask

  task automatic test_rr_wrap();
    logic [3:0] vec [5] = '{4'b0100, 4'b0011, 4'b0011, 4'b1001, 4'b1001};
    int exp_g [5] = '{2, 0, 1, 3, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      MODE = 1'b1; VALID = vec[i]; D = 16'h9876; OUT_READY = 1'b1;
      #1;
      n_checks++; if (READY !== (4'b0001 << exp_g[i])) begin
        n_fail++; $display("FAIL rr_wrap_ready[%0d] got %b exp grant %0d", i, READY, exp_g[i]);
      end
      @(posedge clock); #1;
      n_checks++; if (OUT_SEL !== 2'(exp_g[i]) || OUT !== 4'(4'h6 + exp_g[i])) begin
        n_fail++; $display("FAIL rr_wrap_out[%0d] got sel=%0d out=%h exp sel=%0d", i, OUT_SEL, OUT, exp_g[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    // Holding word from channel 0 (value 6), pointer at 1.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      MODE = 1'b1; VALID = 4'b1111; OUT_READY = 1'b0;
      D = 16'hFFF0 | 16'(i + 1);
      #1;
      n_checks++; if (READY !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0000", i, READY); end
      @(posedge clock); #1;
      n_checks++; if (OUT !== 4'h6 || OUT_SEL !== 2'd0 || OUT_VALID !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d] got out=%h sel=%0d v=%b exp out=6 sel=0 v=1", i, OUT, OUT_SEL, OUT_VALID);
      end
    end
    @(negedge clock);
    D = 16'h1234; OUT_READY = 1'b1;
    #1;
    n_checks++; if (READY !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready got %b exp 0010", READY); end
    @(posedge clock); #1;
    n_checks++; if (OUT !== 4'h3 || OUT_SEL !== 2'd1 || OUT_VALID !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_out got out=%h sel=%0d v=%b exp out=3 sel=1 v=1", OUT, OUT_SEL, OUT_VALID);
    end
  endtask

  task automatic test_withdraw();
    logic [3:0] vec    [7] = '{4'b0100, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    logic       ordy   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_r  [7] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    int         exp_p  [7] = '{-1, -1, -1, 2, -1, 3, -1};
    int hs = 0;
    int pops = 0;
    @(negedge clock);
    VALID = 4'b0000; OUT_READY = 1'b1; D = 16'hDCBA;
    @(posedge clock); #1;
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL wd_drain got v=%b exp 0", OUT_VALID); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      VALID = vec[i]; OUT_READY = ordy[i];
      #1;
      n_checks++; if (READY !== exp_r[i]) begin
        n_fail++; $display("FAIL wd_ready[%0d] got %b exp %b", i, READY, exp_r[i]);
      end
      if ((VALID & READY) != 4'b0000) hs++;
      n_checks++; if ((OUT_VALID & OUT_READY) !== (exp_p[i] >= 0)) begin
        n_fail++; $display("FAIL wd_pop_flag[%0d] got %b exp %b", i, OUT_VALID & OUT_READY, exp_p[i] >= 0);
      end
      if (OUT_VALID && OUT_READY) begin
        pops++;
        n_checks++; if (OUT_SEL !== 2'(exp_p[i]) || OUT !== 4'(4'hA + exp_p[i])) begin
          n_fail++; $display("FAIL wd_pop[%0d] got sel=%0d out=%h exp sel=%0d", i, OUT_SEL, OUT, exp_p[i]);
        end
      end
      @(posedge clock);
    end
    n_checks++; if (hs != 2) begin n_fail++; $display("FAIL wd_handshakes got %0d exp 2", hs); end
    n_checks++; if (pops != hs) begin n_fail++; $display("FAIL wd_one_out_per_hs got pops=%0d exp %0d", pops, hs); end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_rr_fair();
    test_rr_wrap();
    test_backpressure();
    test_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
